// File: rtl/serial_subtractor_if.sv
// Start/done bus for the bit-serial subtractor: request side (master) and
// arithmetic unit side (slave), plus an FSM state tap for checkers.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic [1:0]       dbg_state;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero, dbg_state
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero, dbg_state
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, using one full-subtractor cell and a borrow
// flop. Result, borrow and zero are registered on the edge entering DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  // Full-subtractor cell on the current LSBs.
  logic             a0, b0, d_bit, bout;
  logic [WIDTH-1:0] r_next;

  assign a0     = a_sh_q[0];
  assign b0     = b_sh_q[0];
  assign d_bit  = a0 ^ b0 ^ bin_q;
  assign bout   = (~a0 & b0) | (~(a0 ^ b0) & bin_q);
  assign r_next = {d_bit, r_sh_q[WIDTH-1:1]};

  // Handshake: start is sampled only in IDLE, and a/b are captured on that
  // same edge; done is a one-cycle pulse, with diff/borrow/zero valid from
  // that cycle until the next done. start outside IDLE is dropped.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          r_sh_d  = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        r_sh_d = r_next;
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        bin_d  = bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d   = r_next;
          borrow_d = bout;
          zero_d   = (r_next == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.zero      = zero_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: driver tasks push hand-computed
// results into exp_q, a negedge monitor pops and compares on each done.
module tb_serial_subtractor;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  int           n_checks   = 0;
  int           n_fail     = 0;
  int           done_count = 0;
  logic [W+1:0] exp_q[$];      // {borrow, zero, diff}
  logic [W+1:0] exp_e;
  logic         prev_done  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      if (prev_done) chk("done_width", {63'd0, sif.done}, 64'd0);
      if (sif.done && !prev_done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 diff=0x%0h expected no pending operation", sif.diff);
        end else begin
          exp_e = exp_q.pop_front();
          chk("diff",   {56'd0, sif.diff},   {56'd0, exp_e[W-1:0]});
          chk("zero",   {63'd0, sif.zero},   {63'd0, exp_e[W]});
          chk("borrow", {63'd0, sif.borrow}, {63'd0, exp_e[W+1]});
        end
      end
      prev_done <= sif.done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!sif.busy && !sif.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle within 40 cycles", sif.busy, sif.done);
    end
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic eb, input logic ez);
    wait_idle();
    sif.a     = a;
    sif.b     = b;
    sif.start = 1'b1;
    exp_q.push_back({eb, ez, ed});
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_n, output int cyc);
    bit ok = 1'b0;
    busy_n = sif.busy ? 1 : 0;
    cyc    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (sif.done) begin
        ok = 1'b1;
        break;
      end
      if (sif.busy) busy_n++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int bn, cyc, dc, gap;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy",   {63'd0, sif.busy},      64'd0);
    chk("rst_done",   {63'd0, sif.done},      64'd0);
    chk("rst_diff",   {56'd0, sif.diff},      64'd0);
    chk("rst_borrow", {63'd0, sif.borrow},    64'd0);
    chk("rst_zero",   {63'd0, sif.zero},      64'd0);
    chk("rst_state",  {62'd0, sif.dbg_state}, 64'd0);
    rst_n = 1'b1;

    // 5 - 3, with latency and busy-length checks
    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    wait_done(bn, cyc);
    chk("busy_cycles",  64'(bn),  64'd8);
    chk("done_latency", 64'(cyc), 64'd8);

    issue(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0); wait_done(bn, cyc);
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0); wait_done(bn, cyc);
    issue(8'h00, 8'h00, 8'h00, 1'b0, 1'b1); wait_done(bn, cyc);
    issue(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1); wait_done(bn, cyc);
    issue(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0); wait_done(bn, cyc);

    // start pulsed and operands changed mid-operation are ignored
    issue(8'h09, 8'h04, 8'h05, 1'b0, 1'b0);
    dc = done_count;
    repeat (2) @(negedge clk);
    sif.a     = 8'h01;
    sif.b     = 8'h02;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    sif.a     = 8'hAA;
    sif.b     = 8'h55;
    wait_done(bn, cyc);
    repeat (12) @(negedge clk);
    chk("ignored_start_dones", 64'(done_count - dc), 64'd1);
    chk("ignored_start_busy",  {63'd0, sif.busy},    64'd0);

    // asynchronous reset in SHIFT aborts without a done pulse
    wait_idle();
    sif.a     = 8'h10;
    sif.b     = 8'h01;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",   {63'd0, sif.busy},      64'd0);
    chk("abort_done",   {63'd0, sif.done},      64'd0);
    chk("abort_diff",   {56'd0, sif.diff},      64'd0);
    chk("abort_borrow", {63'd0, sif.borrow},    64'd0);
    chk("abort_zero",   {63'd0, sif.zero},      64'd0);
    chk("abort_state",  {62'd0, sif.dbg_state}, 64'd0);
    dc = done_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", 64'(done_count - dc), 64'd0);
    issue(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0); wait_done(bn, cyc);

    // start held high: back-to-back operations
    wait_idle();
    sif.a     = 8'h07;
    sif.b     = 8'h02;
    sif.start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h05});
    @(negedge clk);
    sif.a = 8'h02;
    sif.b = 8'h07;
    exp_q.push_back({1'b1, 1'b0, 8'hFB});
    wait_done(bn, cyc);
    gap = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      gap++;
      if (sif.done) break;
      chk("diff_stable", {56'd0, sif.diff}, 64'h05);
    end
    sif.start = 1'b0;
    chk("b2b_gap", 64'(gap), 64'd10);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_total",  64'(done_count),   64'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing a − b, least significant bit first, with one full-subtractor cell and a borrow flip-flop.
- Counterpart to the combinational half-adder/full-adder arithmetic blocks: it is the subtract direction, built sequentially.
- Sits behind a start/done handshake so the course ALU datapath and self-checking benches can drive it.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2–32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a subtraction; sampled only in IDLE
- a  input  WIDTH  minuend; sampled on the accepting edge only
- b  input  WIDTH  subtrahend; sampled on the accepting edge only
- busy  output  1  high while in SHIFT
- done  output  1  single-cycle pulse; result valid
- diff  output  WIDTH  registered result a − b mod 2^WIDTH
- borrow  output  1  final borrow out; 1 iff a < b unsigned
- zero  output  1  registered; 1 iff diff == 0

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - state=IDLE, busy=0, done=0, diff=0, borrow=0, zero=0.
  - Internal shift registers, bit counter and borrow flip-flop all cleared.
  - A reset mid-operation aborts the operation; no done pulse is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: load a_sh←a, b_sh←b, r_sh←0, bin←0, cnt←0; go to SHIFT.
  - Otherwise hold.
- SHIFT, one bit per edge:
  - a0=a_sh[0], b0=b_sh[0].
  - d = a0 ^ b0 ^ bin.
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - r_sh ← {d, r_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; bin ← bout; cnt ← cnt+1.
  - On the edge processing bit WIDTH−1 (cnt==WIDTH−1): go to DONE and, on that same edge, register diff←{d, r_sh[WIDTH-1:1]}, borrow←bout, zero←(that value == 0).
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Outputs are Moore:
  - busy = (state==SHIFT).
  - done = (state==DONE).
- Latency:
  - Start accepted at edge E0 → busy high from E0 to E_WIDTH → done high for exactly one cycle after edge E_WIDTH.
  - With WIDTH=8: done rises 8 edges after the accepting edge.
- Throughput: at most one operation per WIDTH+2 cycles. start held high continuously gives back-to-back operations, each re-sampling a and b in IDLE.
- start while in SHIFT or DONE is ignored; it is neither queued nor does it disturb the operation in progress.
- a and b may change freely after the accepting edge without affecting the result.
- diff, borrow and zero hold their last values through IDLE and the next SHIFT. They update only on the edge entering DONE.
- Counter width: $clog2(WIDTH)+1 bits, so no wrap-around occurs before termination.
- Arithmetic is unsigned modulo 2^WIDTH. Results are identical to a − b truncated to WIDTH bits, with borrow as bit WIDTH of the two's-complement subtraction inverted carry.

Test Plan (WIDTH=8):
- Reset, then a=5, b=3, start pulsed for one cycle → busy for 8 cycles; done pulse on cycle 9; diff=0x02, borrow=0, zero=0. The bench also checks done is exactly one cycle wide.
- a=3, b=5 → diff=0xFE, borrow=1, zero=0. Then a=0x80, b=0x01 → diff=0x7F, borrow=0.
- Corner operands:
  - a=0x00, b=0x00 → diff=0x00, borrow=0, zero=1.
  - a=0xFF, b=0xFF → diff=0x00, zero=1.
  - a=0x00, b=0xFF → diff=0x01, borrow=1.
- Start a=9, b=4; while busy, pulse start with a=1, b=2 and change the a/b inputs → single done pulse with diff=0x05. No second operation starts.
- Start a=0x10, b=0x01; assert rst_n low at SHIFT cycle 4 → all outputs 0 immediately, no done pulse. After release, a=0x10, b=0x01 completes with diff=0x0F.
- Hold start=1 with a=7, b=2, then a=2, b=7 presented on the next IDLE edge:
  - First done: diff=0x05, borrow=0.
  - Second done 10 cycles later: diff=0xFB, borrow=1.
  - diff is stable between the two done pulses.
